fdc_fifo_ctrl: RTL

FDC_FIFO_CTRL -- requirements
Module: fdc_fifo_ctrl

---
 rtl/fdc_pkg.sv | 17 +
 rtl/fdc_fifo_ctrl_if.sv | 46 ++++
 rtl/simple_fifo.sv | 61 ++++++
 rtl/fdc_fifo_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/fdc_pkg.sv
// Shared types for the floppy-controller FIFO slice: FSM states, direction
// encodings and the byte type used on every data path.
package fdc_pkg;

    typedef logic [7:0] fdc_byte_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_BURST = 2'd2,
        ST_DONE  = 2'd3
    } fdc_state_t;

    localparam logic DIR_WRITE = 1'b0;  // host-to-disk
    localparam logic DIR_READ  = 1'b1;  // disk-to-host

endpackage

// File: rtl/fdc_fifo_ctrl_if.sv
// Host/disk handshake bundle of fdc_fifo_ctrl; master drives strobes and data,
// slave (the controller) returns FIFO head, status and request lines.
interface fdc_fifo_ctrl_if
    import fdc_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
);
    logic                  sclr;
    logic                  dir;
    logic                  dma_en;
    logic                  thresh_wr;
    logic [DEPTH_LOG2-1:0] thresh_val;
    logic                  pio_rd;
    logic                  pio_wr;
    fdc_byte_t             pio_wdata;
    logic                  dack;
    logic                  tc;
    logic                  dsk_push;
    fdc_byte_t             dsk_wdata;
    logic                  dsk_pop;

    fdc_byte_t             host_rdata;
    fdc_byte_t             dsk_rdata;
    logic                  drq;
    logic                  pio_rqm;
    logic                  dsk_avail;
    logic                  dsk_space;
    logic                  overrun;
    logic                  underrun;
    logic                  done_irq;
    logic [DEPTH_LOG2:0]   level;

    modport master (
        output sclr, dir, dma_en, thresh_wr, thresh_val, pio_rd, pio_wr, pio_wdata,
               dack, tc, dsk_push, dsk_wdata, dsk_pop,
        input  host_rdata, dsk_rdata, drq, pio_rqm, dsk_avail, dsk_space,
               overrun, underrun, done_irq, level
    );

    modport slave (
        input  sclr, dir, dma_en, thresh_wr, thresh_val, pio_rd, pio_wr, pio_wdata,
               dack, tc, dsk_push, dsk_wdata, dsk_pop,
        output host_rdata, dsk_rdata, drq, pio_rqm, dsk_avail, dsk_space,
               overrun, underrun, done_irq, level
    );
endinterface

// File: rtl/simple_fifo.sv
// Show-ahead single-clock FIFO: q is the head entry combinationally, usedw wraps
// to 0 when full so callers combine {full, usedw} for the true occupancy.
module simple_fifo #(
    parameter int WIDTH  = 8,
    parameter int WIDTHU = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclr,
    input  logic              wrreq,
    input  logic [WIDTH-1:0]  data,
    input  logic              rdreq,
    output logic [WIDTH-1:0]  q,
    output logic              full,
    output logic              empty,
    output logic [WIDTHU-1:0] usedw
);
    localparam int DEPTH = 1 << WIDTHU;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [WIDTHU-1:0] wr_ptr_reg;
    logic [WIDTHU-1:0] rd_ptr_reg;
    logic [WIDTHU:0]   count_reg;
    logic              do_wr;
    logic              do_rd;

    // A write into a full FIFO is legal only when the head is leaving the same cycle.
    assign do_wr = wrreq && !sclr && (!count_reg[WIDTHU] || rdreq);
    assign do_rd = rdreq && !sclr && (count_reg != '0);

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_reg] <= data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (sclr) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign q     = mem[rd_ptr_reg];
    assign full  = count_reg[WIDTHU];
    assign empty = (count_reg == '0);
    assign usedw = count_reg[WIDTHU-1:0];
endmodule

// File: rtl/fdc_fifo_ctrl.sv
// FDC data FIFO controller: PIO/DMA host side, disk-core side, threshold-driven DMA bursts.
// Optional FDC_FIFO_STATS_EN adds a saturating host-byte counter on port xfer_count.
module fdc_fifo_ctrl
    import fdc_pkg::*;
#(
    parameter int DEPTH_LOG2     = 4,
    parameter int DEFAULT_THRESH = 8
) (
    input  logic               clk,
    input  logic               rst,
    fdc_fifo_ctrl_if.slave     bus
`ifdef FDC_FIFO_STATS_EN
    ,
    output logic [15:0]        xfer_count
`endif
);
    localparam logic [DEPTH_LOG2:0]   FIFO_DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2-1:0] THRESH_RST = DEFAULT_THRESH[DEPTH_LOG2-1:0];

    fdc_state_t            state_reg, state_next;
    logic                  dir_reg;
    logic                  drq_reg;
    logic                  overrun_reg;
    logic                  underrun_reg;
    logic [DEPTH_LOG2-1:0] thresh_reg;

    logic                  dir_eff;
    logic                  host_strobe;
    logic                  push_req, pop_req;
    logic                  do_push, do_pop;
    logic                  fifo_full, fifo_empty;
    logic [DEPTH_LOG2-1:0] fifo_usedw;
    fdc_byte_t             fifo_q;
    fdc_byte_t             fifo_data;
    logic [DEPTH_LOG2:0]   level;
    logic [DEPTH_LOG2:0]   free_slots;
    logic [DEPTH_LOG2:0]   thresh_eff;
    logic                  burst_ready;
    logic                  burst_end;

    // Direction is live while idle and frozen once a transfer has started.
    assign dir_eff = (state_reg == ST_IDLE) ? bus.dir : dir_reg;

    // The host side is either the DMA channel or the CPU, never both.
    assign host_strobe = bus.dma_en ? bus.dack
                                    : ((dir_eff == DIR_WRITE) ? bus.pio_wr : bus.pio_rd);

    assign push_req  = !bus.sclr && ((dir_eff == DIR_WRITE) ? host_strobe : bus.dsk_push);
    assign pop_req   = !bus.sclr && ((dir_eff == DIR_WRITE) ? bus.dsk_pop : host_strobe);
    assign do_push   = push_req && (!fifo_full || pop_req);
    assign do_pop    = pop_req && !fifo_empty;
    // The host data bus carries both PIO and DMA write bytes.
    assign fifo_data = (dir_eff == DIR_WRITE) ? bus.pio_wdata : bus.dsk_wdata;

    simple_fifo #(
        .WIDTH  (8),
        .WIDTHU (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .sclr  (bus.sclr),
        .wrreq (do_push),
        .data  (fifo_data),
        .rdreq (do_pop),
        .q     (fifo_q),
        .full  (fifo_full),
        .empty (fifo_empty),
        .usedw (fifo_usedw)
    );

    assign level       = {fifo_full, fifo_usedw};
    assign free_slots  = FIFO_DEPTH - level;
    assign thresh_eff  = (thresh_reg == '0) ? {{DEPTH_LOG2{1'b0}}, 1'b1} : {1'b0, thresh_reg};
    assign burst_ready = bus.dma_en && ((dir_eff == DIR_READ) ? (level >= thresh_eff)
                                                              : (free_slots >= thresh_eff));
    assign burst_end   = (dir_eff == DIR_READ) ? fifo_empty : fifo_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            drq_reg   <= 1'b0;
            dir_reg   <= DIR_WRITE;
        end else begin
            state_reg <= state_next;
            drq_reg   <= (state_next == ST_BURST);
            if (state_reg == ST_IDLE) dir_reg <= bus.dir;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (bus.sclr) begin
            state_next = ST_IDLE;
        end else begin
            unique case (state_reg)
                ST_IDLE:  if (do_push || do_pop) state_next = ST_XFER;
                ST_XFER:  if (burst_ready) state_next = ST_BURST;
                ST_BURST: begin
                    if (bus.dma_en && bus.dack && bus.tc) state_next = ST_DONE;
                    else if (burst_end)                    state_next = ST_XFER;
                end
                ST_DONE:  state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.drq      = drq_reg;
        bus.done_irq = 1'b0;
        if (state_reg == ST_DONE) bus.done_irq = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_reg  <= 1'b0;
            underrun_reg <= 1'b0;
            thresh_reg   <= THRESH_RST;
        end else begin
            if (bus.thresh_wr) thresh_reg <= bus.thresh_val;
            if (bus.sclr) begin
                overrun_reg  <= 1'b0;
                underrun_reg <= 1'b0;
            end else begin
                if (push_req && !do_push) overrun_reg  <= 1'b1;
                if (pop_req && !do_pop)   underrun_reg <= 1'b1;
            end
        end
    end

    assign bus.host_rdata = fifo_q;
    assign bus.dsk_rdata  = fifo_q;
    assign bus.pio_rqm    = (dir_eff == DIR_READ) ? !fifo_empty : !fifo_full;
    assign bus.dsk_avail  = (dir_eff == DIR_WRITE) && !fifo_empty;
    assign bus.dsk_space  = (dir_eff == DIR_READ) && !fifo_full;
    assign bus.overrun    = overrun_reg;
    assign bus.underrun   = underrun_reg;
    assign bus.level      = level;

`ifdef FDC_FIFO_STATS_EN
    logic        host_acc;
    logic [15:0] xfer_count_reg;

    assign host_acc = (dir_eff == DIR_WRITE) ? do_push : do_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_count_reg <= '0;
        end else if (bus.sclr) begin
            xfer_count_reg <= '0;
        end else if (state_reg == ST_IDLE && state_next == ST_XFER) begin
            // The byte that opens the transfer is the first one counted.
            xfer_count_reg <= host_acc ? 16'd1 : 16'd0;
        end else if (host_acc && xfer_count_reg != 16'hFFFF) begin
            xfer_count_reg <= xfer_count_reg + 16'd1;
        end
    end

    assign xfer_count = xfer_count_reg;
`endif
endmodule
